lsu_byte_master: RTL

- Load/store initiator between the core datapath and the byte-organised data memory.
- Takes one load or store request per transaction (size from RISC-V funct3) and serialises it into one byte access per cycle on the memory port.
- Byte order is big-endian: the lowest address holds the most significant byte.
- Assembles load results with sign or zero extension to 64 bits and reports completion or misalignment to the core.

---
 rtl/lsu_byte_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_byte_master.sv
// lsu_byte_master: serialises one load/store into big-endian byte accesses
// and returns sign/zero-extended load data with a done/err pulse.
module lsu_byte_master #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [63:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [63:0]           load_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    WR_ISSUE,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [2:0]            cnt_q;
  logic [2:0]            cnt_nx;
  logic [63:0]           sreg_q;
  logic [63:0]           acc_q;
  logic [63:0]           acc_nx;
  logic                  rd_pend_q;

  logic [2:0]  last_in;
  logic [2:0]  last_q;
  logic        illegal;
  logic [5:0]  st_shift;
  logic [63:0] aligned;
  logic [63:0] ext;
  logic        sgn;

  function automatic logic [2:0] last_of(input logic [1:0] sz);
    logic [2:0] r;
    unique case (sz)
      2'b00:   r = 3'd0;
      2'b01:   r = 3'd1;
      2'b10:   r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  always_comb begin
    last_in = last_of(funct3[1:0]);
    last_q  = last_of(f3_q[1:0]);
    illegal = (funct3 == 3'b111)
            | (is_store & funct3[2])
            | ((addr[2:0] & last_in) != 3'd0);
    // left-justify the store value so bytes leave from bit 63 down
    unique case (funct3[1:0])
      2'b00:   st_shift = 6'd56;
      2'b01:   st_shift = 6'd48;
      2'b10:   st_shift = 6'd32;
      default: st_shift = 6'd0;
    endcase
    aligned = store_data << st_shift;
    cnt_nx  = cnt_q + 3'd1;
  end

  always_comb begin
    acc_nx = {acc_q[55:0], mem_rdata};
    sgn    = ~f3_q[2];
    unique case (f3_q[1:0])
      2'b00:   ext = {{56{sgn & acc_nx[7]}}, acc_nx[7:0]};
      2'b01:   ext = {{48{sgn & acc_nx[15]}}, acc_nx[15:0]};
      2'b10:   ext = {{32{sgn & acc_nx[31]}}, acc_nx[31:0]};
      default: ext = acc_nx;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal)       state_d = FIN;
          else if (is_store) state_d = WR_ISSUE;
          else               state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: if (cnt_q == last_q) state_d = RD_DRAIN;
      RD_DRAIN: state_d = FIN;
      WR_ISSUE: if (cnt_q == last_q) state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      f3_q      <= '0;
      cnt_q     <= '0;
      sreg_q    <= '0;
      acc_q     <= '0;
      rd_pend_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // read data trails its strobe by one cycle
      rd_pend_q <= mem_read;
      if (rd_pend_q) acc_q <= acc_nx;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= addr;
            f3_q   <= funct3;
            cnt_q  <= 3'd0;
            acc_q  <= '0;
            busy   <= 1'b1;
            if (illegal) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (is_store) begin
              mem_write <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= aligned[63:56];
              sreg_q    <= aligned << 8;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= addr;
            end
          end
        end
        RD_ISSUE: begin
          if (cnt_q == last_q) begin
            mem_read <= 1'b0;
          end else begin
            cnt_q    <= cnt_nx;
            mem_addr <= addr_q + ADDR_WIDTH'(cnt_nx);
          end
        end
        RD_DRAIN: begin
          done      <= 1'b1;
          err       <= 1'b0;
          load_data <= ext;
        end
        WR_ISSUE: begin
          if (cnt_q == last_q) begin
            mem_write <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b0;
          end else begin
            cnt_q     <= cnt_nx;
            mem_addr  <= addr_q + ADDR_WIDTH'(cnt_nx);
            mem_wdata <= sreg_q[63:56];
            sreg_q    <= sreg_q << 8;
          end
        end
        FIN: begin
          done <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
